// File: rtl/usb_data_buffer_mw.sv
// usb_data_buffer_mw
// Shared byte FIFO between the AHB subordinate and the USB RX/TX engines.
// The AHB side moves 1, 2 or 4 bytes per access (little-endian packing);
// the USB side moves one byte per access. Rejected accesses set sticky
// overflow/underflow flags. When both ports strobe in the same direction
// in one cycle, the USB port wins.
//
// Optional feature: define DB_WATERMARK_EN to add a registered watermark
// output that is high when occupancy >= WM_LEVEL.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   flush, clear             USB-side / AHB-side empty requests
//   store_tx_data, tx_data,
//   tx_size                  AHB push (size 0=1B, 1=2B, 2=4B, 3=illegal)
//   get_rx_data, rx_size,
//   rx_data                  AHB pop and lookahead of the next rx_size bytes
//   store_rx_packet_data,
//   rx_packet_data           USB push of one byte
//   get_tx_packet_data,
//   tx_packet_data           USB pop and lookahead of the head byte
//   buffer_occupancy, full,
//   empty                    fill status
//   overflow, underflow,
//   err_clr                  sticky error flags and their clear
//   watermark                occupancy threshold (DB_WATERMARK_EN only)
module usb_data_buffer_mw #(
    parameter int DEPTH    = 64,
    parameter int WM_LEVEL = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     clear,
    input  logic                     store_tx_data,
    input  logic [31:0]              tx_data,
    input  logic [1:0]               tx_size,
    input  logic                     get_rx_data,
    input  logic [1:0]               rx_size,
    output logic [31:0]              rx_data,
    input  logic                     store_rx_packet_data,
    input  logic [7:0]               rx_packet_data,
    input  logic                     get_tx_packet_data,
    output logic [7:0]               tx_packet_data,
    output logic [$clog2(DEPTH):0]   buffer_occupancy,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     underflow,
`ifdef DB_WATERMARK_EN
    output logic                     watermark,
`endif
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    // Size code to byte count; the illegal code maps to 0 so it is always rejected.
    function automatic logic [2:0] size_bytes(input logic [1:0] code);
        case (code)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_next;
    logic [OW-1:0] free_bytes;
    logic [2:0]    push_n;
    logic [2:0]    pop_n;
    logic [2:0]    rx_m;
    logic [31:0]   push_bytes;
    logic          push_req;
    logic          pop_req;
    logic          push_ok;
    logic          pop_ok;
    logic          ovf_set;
    logic          unf_set;
    logic          empty_req;

    assign empty_req  = flush | clear;
    assign free_bytes = OW'(DEPTH) - occ;

    // Push arbitration: USB wins, a colliding AHB push counts as an overflow.
    always_comb begin
        push_req   = 1'b0;
        push_n     = 3'd0;
        push_bytes = 32'd0;
        push_ok    = 1'b0;
        ovf_set    = 1'b0;
        if (store_rx_packet_data) begin
            push_req   = 1'b1;
            push_n     = 3'd1;
            push_bytes = {24'd0, rx_packet_data};
            ovf_set    = store_tx_data;
        end else if (store_tx_data) begin
            push_req   = 1'b1;
            push_n     = size_bytes(tx_size);
            push_bytes = tx_data;
        end
        if (push_req) begin
            if (push_n != 3'd0 && free_bytes >= OW'(push_n)) begin
                push_ok = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
    end

    // Pop arbitration mirrors the push side, judged on start-of-cycle occupancy.
    always_comb begin
        pop_req = 1'b0;
        pop_n   = 3'd0;
        pop_ok  = 1'b0;
        unf_set = 1'b0;
        if (get_tx_packet_data) begin
            pop_req = 1'b1;
            pop_n   = 3'd1;
            unf_set = get_rx_data;
        end else if (get_rx_data) begin
            pop_req = 1'b1;
            pop_n   = size_bytes(rx_size);
        end
        if (pop_req) begin
            if (pop_n != 3'd0 && occ >= OW'(pop_n)) begin
                pop_ok = 1'b1;
            end else begin
                unf_set = 1'b1;
            end
        end
    end

    always_comb begin
        occ_next = occ;
        if (empty_req) begin
            occ_next = '0;
        end else begin
            occ_next = occ + (push_ok ? OW'(push_n) : OW'(0))
                           - (pop_ok ? OW'(pop_n) : OW'(0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (empty_req) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push_ok) wptr <= wptr + AW'(push_n);
                if (pop_ok)  rptr <= rptr + AW'(pop_n);
            end
            occ       <= occ_next;
            // A new error in the same cycle as err_clr must survive.
            overflow  <= (overflow  & ~err_clr) | ovf_set;
            underflow <= (underflow & ~err_clr) | unf_set;
        end
    end

    // Storage is not reset: occupancy gates every read, so stale bytes never escape.
    always_ff @(posedge clk) begin
        if (push_ok && !empty_req) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(push_n)) begin
                    mem[wptr + AW'(k)] <= push_bytes[8*k +: 8];
                end
            end
        end
    end

    assign rx_m = size_bytes(rx_size);

    // Lookahead bytes are zeroed past the requested size or the stored data.
    always_comb begin
        rx_data = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(rx_m) && k < int'(occ)) begin
                rx_data[8*k +: 8] = mem[rptr + AW'(k)];
            end
        end
    end

    assign tx_packet_data   = (occ != '0) ? mem[rptr] : 8'd0;
    assign buffer_occupancy = occ;
    assign full             = (occ == OW'(DEPTH));
    assign empty            = (occ == '0);

`ifdef DB_WATERMARK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            watermark <= 1'b0;
        end else if (empty_req) begin
            watermark <= 1'b0;
        end else begin
            watermark <= (occ_next >= OW'(WM_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_usb_data_buffer_mw.sv
// tb_usb_data_buffer_mw
// Self-checking bench for usb_data_buffer_mw. A byte queue plus two flag
// bits model the buffer; every cycle the DUT outputs are compared against
// the queue contents, then the queue is updated from the applied strobes.
// Directed sequences cover the listed scenarios, followed by randomized
// traffic in push-heavy, pop-heavy and mixed phases.
module tb_usb_data_buffer_mw;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, clear;
    logic        store_tx_data;
    logic [31:0] tx_data;
    logic [1:0]  tx_size;
    logic        get_rx_data;
    logic [1:0]  rx_size;
    logic [31:0] rx_data;
    logic        store_rx_packet_data;
    logic [7:0]  rx_packet_data;
    logic        get_tx_packet_data;
    logic [7:0]  tx_packet_data;
    logic [6:0]  buffer_occupancy;
    logic        full, empty, overflow, underflow, err_clr;
`ifdef DB_WATERMARK_EN
    logic        watermark;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    bit         mOvf;
    bit         mUnf;

    always #5 clk = ~clk;

    usb_data_buffer_mw #(.DEPTH(DEPTH), .WM_LEVEL(48)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .clear               (clear),
        .store_tx_data       (store_tx_data),
        .tx_data             (tx_data),
        .tx_size             (tx_size),
        .get_rx_data         (get_rx_data),
        .rx_size             (rx_size),
        .rx_data             (rx_data),
        .store_rx_packet_data(store_rx_packet_data),
        .rx_packet_data      (rx_packet_data),
        .get_tx_packet_data  (get_tx_packet_data),
        .tx_packet_data      (tx_packet_data),
        .buffer_occupancy    (buffer_occupancy),
        .full                (full),
        .empty               (empty),
        .overflow            (overflow),
        .underflow           (underflow),
`ifdef DB_WATERMARK_EN
        .watermark           (watermark),
`endif
        .err_clr             (err_clr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sizeOf(input logic [1:0] code);
        return (code == 2'd3) ? 0 : (1 << code);
    endfunction

    function automatic logic [31:0] expRx(input logic [1:0] rs);
        logic [31:0] r = 32'd0;
        for (int k = 0; k < sizeOf(rs); k++) begin
            if (k < q.size()) r[8*k +: 8] = q[k];
        end
        return r;
    endfunction

    task automatic checkModel();
        checkOutput("occupancy", 32'(buffer_occupancy), 32'(q.size()));
        checkOutput("empty",     32'(empty),            32'(q.size() == 0));
        checkOutput("full",      32'(full),             32'(q.size() == DEPTH));
        checkOutput("tx_packet", 32'(tx_packet_data),   (q.size() > 0) ? 32'(q[0]) : 32'd0);
        checkOutput("rx_data",   rx_data,               expRx(rx_size));
        checkOutput("overflow",  32'(overflow),         32'(mOvf));
        checkOutput("underflow", 32'(underflow),        32'(mUnf));
    endtask

    task automatic modelStep(input logic sTx, input logic [31:0] d, input logic [1:0] ts,
                             input logic gRx, input logic [1:0] rs,
                             input logic sRx, input logic [7:0] b,
                             input logic gTx, input logic fl, input logic cl, input logic ec);
        int occ0 = q.size();
        int n = -1;
        int m = -1;
        bit oSet = 0, uSet = 0, pushOk = 0, popOk = 0;
        logic [7:0] pb [4];
        if (sRx) begin
            n = 1; pb[0] = b; oSet = sTx;
        end else if (sTx) begin
            n = sizeOf(ts);
            for (int k = 0; k < 4; k++) pb[k] = d[8*k +: 8];
        end
        if (n >= 0) begin
            if (n > 0 && DEPTH - occ0 >= n) pushOk = 1; else oSet = 1;
        end
        if (gTx) begin
            m = 1; uSet = gRx;
        end else if (gRx) begin
            m = sizeOf(rs);
        end
        if (m >= 0) begin
            if (m > 0 && occ0 >= m) popOk = 1; else uSet = 1;
        end
        if (fl || cl) begin
            q.delete();
        end else begin
            if (popOk)  for (int k = 0; k < m; k++) void'(q.pop_front());
            if (pushOk) for (int k = 0; k < n; k++) q.push_back(pb[k]);
        end
        mOvf = (mOvf && !ec) || oSet;
        mUnf = (mUnf && !ec) || uSet;
    endtask

    task automatic driveIdle();
        store_tx_data = 0; tx_data = 0; tx_size = 0;
        get_rx_data = 0; rx_size = 2'd2;
        store_rx_packet_data = 0; rx_packet_data = 0;
        get_tx_packet_data = 0; flush = 0; clear = 0; err_clr = 0;
    endtask

    // One clock: drive, check pre-edge outputs against the model, clock, update model.
    task automatic applyStimulus(input logic sTx, input logic [31:0] d, input logic [1:0] ts,
                                 input logic gRx, input logic [1:0] rs,
                                 input logic sRx, input logic [7:0] b,
                                 input logic gTx, input logic fl, input logic cl, input logic ec);
        store_tx_data = sTx; tx_data = d; tx_size = ts;
        get_rx_data = gRx; rx_size = rs;
        store_rx_packet_data = sRx; rx_packet_data = b;
        get_tx_packet_data = gTx; flush = fl; clear = cl; err_clr = ec;
        #1;
        checkModel();
        @(posedge clk);
        modelStep(sTx, d, ts, gRx, rs, sRx, b, gTx, fl, cl, ec);
        #1;
        driveIdle();
    endtask

    task automatic ahbPush(input logic [31:0] d, input logic [1:0] ts);
        applyStimulus(1, d, ts, 0, 2'd2, 0, 8'd0, 0, 0, 0, 0);
    endtask
    task automatic ahbPop(input logic [1:0] rs);
        applyStimulus(0, 0, 2'd0, 1, rs, 0, 8'd0, 0, 0, 0, 0);
    endtask
    task automatic usbPush(input logic [7:0] b);
        applyStimulus(0, 0, 2'd0, 0, 2'd2, 1, b, 0, 0, 0, 0);
    endtask
    task automatic usbPop();
        applyStimulus(0, 0, 2'd0, 0, 2'd2, 0, 8'd0, 1, 0, 0, 0);
    endtask
    task automatic doFlush();
        applyStimulus(0, 0, 2'd0, 0, 2'd2, 0, 8'd0, 0, 1, 0, 0);
    endtask
    task automatic errClr();
        applyStimulus(0, 0, 2'd0, 0, 2'd2, 0, 8'd0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [7:0] expBytes [4];
        driveIdle();
        rst = 1'b1;
        mOvf = 0; mUnf = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_occ",   32'(buffer_occupancy), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full",  32'(full), 32'd0);
        checkOutput("rst_rx",    rx_data, 32'd0);
        checkOutput("rst_txpk",  32'(tx_packet_data), 32'd0);
        checkOutput("rst_ovf",   32'(overflow), 32'd0);
        checkOutput("rst_unf",   32'(underflow), 32'd0);

        // AHB 4-byte push, four USB pops in little-endian order
        ahbPush(32'hDDCCBBAA, 2'd2);
        expBytes[0] = 8'hAA; expBytes[1] = 8'hBB; expBytes[2] = 8'hCC; expBytes[3] = 8'hDD;
        for (int i = 0; i < 4; i++) begin
            checkOutput("le_byte", 32'(tx_packet_data), 32'(expBytes[i]));
            checkOutput("le_occ",  32'(buffer_occupancy), 32'(4 - i));
            usbPop();
        end
        checkOutput("le_occ_end", 32'(buffer_occupancy), 32'd0);

        // USB pushes, AHB 2-byte lookahead and pop
        usbPush(8'h11); usbPush(8'h22); usbPush(8'h33);
        rx_size = 2'd1;
        #1 checkOutput("rx_lookahead", rx_data, 32'h0000_2211);
        ahbPop(2'd1);
        checkOutput("rx_pop_occ", 32'(buffer_occupancy), 32'd1);
        doFlush();

        // Fill to 62, reject a 4-byte push, accept a 2-byte push
        repeat (15) ahbPush($urandom(), 2'd2);
        ahbPush($urandom(), 2'd1);
        ahbPush(32'hFFFF_FFFF, 2'd2);
        checkOutput("fill_ovf", 32'(overflow), 32'd1);
        checkOutput("fill_occ", 32'(buffer_occupancy), 32'd62);
        ahbPush(32'h0000_BEEF, 2'd1);
        checkOutput("fill_full", 32'(full), 32'd1);
        errClr();
        checkOutput("clr_ovf", 32'(overflow), 32'd0);
        doFlush();

        // Move the pointers to 62 and push across the wrap point
        repeat (15) ahbPush($urandom(), 2'd2);
        ahbPush($urandom(), 2'd1);
        repeat (15) ahbPop(2'd2);
        ahbPop(2'd1);
        ahbPush(32'h4433_2211, 2'd2);
        rx_size = 2'd2;
        #1 checkOutput("wrap_lookahead", rx_data, 32'h4433_2211);
        expBytes[0] = 8'h11; expBytes[1] = 8'h22; expBytes[2] = 8'h33; expBytes[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            checkOutput("wrap_byte", 32'(tx_packet_data), 32'(expBytes[i]));
            usbPop();
        end

        // Colliding pushes: USB byte stored, AHB dropped
        applyStimulus(1, 32'h1234_5678, 2'd2, 0, 2'd2, 1, 8'h5A, 0, 0, 0, 0);
        checkOutput("coll_occ",  32'(buffer_occupancy), 32'd1);
        checkOutput("coll_byte", 32'(tx_packet_data), 32'h5A);
        checkOutput("coll_ovf",  32'(overflow), 32'd1);

        // Flush overrides a push in the same cycle
        applyStimulus(0, 0, 2'd0, 0, 2'd2, 1, 8'h77, 0, 1, 0, 0);
        checkOutput("flush_occ", 32'(buffer_occupancy), 32'd0);
        checkOutput("flush_keeps_ovf", 32'(overflow), 32'd1);

        // Underflow then err_clr
        usbPop();
        checkOutput("unf_set", 32'(underflow), 32'd1);
        errClr();
        checkOutput("errclr_ovf", 32'(overflow), 32'd0);
        checkOutput("errclr_unf", 32'(underflow), 32'd0);

        // Asynchronous reset in the middle of a fill
        for (int i = 0; i < 5; i++) usbPush(8'(i + 1));
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_occ",   32'(buffer_occupancy), 32'd0);
        checkOutput("arst_empty", 32'(empty), 32'd1);
        checkOutput("arst_txpk",  32'(tx_packet_data), 32'd0);
        q.delete(); mOvf = 0; mUnf = 0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic in push-heavy, pop-heavy and mixed phases
        for (int i = 0; i < 1500; i++) begin
            int phase = (i / 100) % 3;
            int pushP = (phase == 0) ? 70 : ((phase == 1) ? 15 : 40);
            int popP  = (phase == 0) ? 15 : ((phase == 1) ? 70 : 40);
            logic sTx, sRx, gTx, gRx, fl, cl, ec;
            logic [1:0] ts, rs;
            sRx = ($urandom_range(0, 99) < pushP / 2);
            sTx = ($urandom_range(0, 99) < pushP);
            gTx = ($urandom_range(0, 99) < popP / 2);
            gRx = ($urandom_range(0, 99) < popP);
            ts  = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rs  = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            fl  = ($urandom_range(0, 99) == 0);
            cl  = ($urandom_range(0, 99) == 0);
            ec  = ($urandom_range(0, 15) == 0);
            if (fl || cl) begin
                sRx = 0; sTx = 0; gTx = 0; gRx = 0;
            end
            applyStimulus(sTx, $urandom(), ts, gRx, rs, sRx, 8'($urandom()), gTx, fl, cl, ec);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_data_buffer_mw.md
Name: usb_data_buffer_mw

Overview:
- Parametrised successor to the USB device byte data buffer. Sits between the AHB subordinate and the USB RX/TX engines.
- Single shared byte FIFO of DEPTH entries.
- AHB side pushes/pops 1, 2 or 4 bytes per access (little-endian packing). USB side pushes/pops 1 byte per access.
- Adds sticky overflow/underflow error reporting and explicit arbitration between the AHB and USB ports.

Parameters:
- DEPTH, 64, FIFO depth in bytes; power of 2, >= 8.
- WM_LEVEL, 48, watermark threshold in bytes; only used with DB_WATERMARK_EN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- flush  input  1  USB-side empty request
- clear  input  1  AHB-side empty request
- store_tx_data  input  1  AHB push strobe
- tx_data  input  32  AHB push data; byte 0 = bits 7:0
- tx_size  input  2  AHB push size: 0=1B, 1=2B, 2=4B, 3=illegal
- get_rx_data  input  1  AHB pop strobe
- rx_size  input  2  AHB pop size, same encoding as tx_size
- rx_data  output  32  lookahead of the next rx_size bytes; unused bytes zero
- store_rx_packet_data  input  1  USB push strobe
- rx_packet_data  input  8  USB push byte
- get_tx_packet_data  input  1  USB pop strobe
- tx_packet_data  output  8  lookahead of the byte at the read pointer
- buffer_occupancy  output  $clog2(DEPTH)+1  bytes stored
- full  output  1  occupancy == DEPTH
- empty  output  1  occupancy == 0
- overflow  output  1  sticky: a push was rejected
- underflow  output  1  sticky: a pop was rejected
- err_clr  input  1  clears overflow and underflow
- watermark  output  1  only present with DB_WATERMARK_EN

Behaviour:
- Reset (rst high, asynchronous):
  - read/write pointers 0, occupancy 0, empty 1, full 0, overflow 0, underflow 0, watermark 0.
  - rx_data and tx_packet_data read 0 while empty.
- Storage: byte array DEPTH x 8. Pointers wrap modulo DEPTH, so a multi-byte access may straddle the wrap point.
- Push size N: 1/2/4 for tx_size 0/1/2; 1 for the USB side. Pop size M is defined the same way.
- Push acceptance:
  - Accepted only if DEPTH - occupancy >= N, using the occupancy at the start of the cycle.
  - Bytes tx_data[8k+7:8k] are written at wptr+k for k < N, then wptr advances by N.
  - A rejected push writes nothing and sets overflow on the next edge.
- Pop acceptance:
  - Accepted only if occupancy >= M, using the start-of-cycle occupancy; rptr then advances by M.
  - A rejected pop moves nothing and sets underflow.
  - rx_data/tx_packet_data are combinational from rptr. Positions beyond occupancy and beyond M read zero.
- tx_size or rx_size == 3: the access is treated as rejected; the matching sticky flag is set.
- Push and pop in the same cycle:
  - Both are allowed. Each acceptance is judged independently on the start-of-cycle occupancy.
  - Next occupancy = occ + N_accepted - M_accepted. A push into a full buffer is rejected even if a pop occurs the same cycle.
- Arbitration:
  - Both push strobes high: the USB push wins; the AHB push is dropped and sets overflow.
  - Both pop strobes high: the USB pop wins; the AHB pop is dropped and sets underflow.
- flush or clear:
  - On the next edge: pointers 0, occupancy 0.
  - Overrides every push/pop in the same cycle.
  - Sticky flags are unaffected.
- err_clr: both sticky flags go to 0 on the next edge. If a new error occurs in the same cycle, setting wins.
- full and empty are decoded combinationally from registered occupancy.
- Latency: a pushed byte is visible at the pop outputs the cycle after the push edge.
- rst asserted mid-transfer: all state is abandoned immediately; no partial data survives.

Optional Feature:
- Macro DB_WATERMARK_EN.
- Defined: adds output watermark, registered, = 1 when the next occupancy >= WM_LEVEL, cleared by flush/clear/rst.
- Undefined: no watermark port, no comparator; WM_LEVEL is ignored.

Test Plan:
- Reset then idle -> occupancy 0, empty 1, full 0, rx_data 0, tx_packet_data 0, flags 0.
- AHB push tx_data=0xDDCCBBAA size 2, then USB pops x4 -> tx_packet_data AA, BB, CC, DD; occupancy 4,3,2,1,0.
- USB push 0x11,0x22,0x33 then AHB pop size 1 -> rx_data 0x00002211 before the pop; occupancy 1.
- DEPTH=64:
  - Fill to 62, then AHB 4-byte push -> rejected, overflow 1, occupancy 62.
  - A 2-byte push then succeeds -> full 1.
- Wrap straddle: set wptr=62, push 0x44332211 size 2 -> bytes land at 62,63,0,1; popping reads them in order.
- Same cycle:
  - USB push + AHB push -> only the USB byte stored, overflow 1.
  - flush + push -> occupancy 0.
  - err_clr -> flags 0.
  - rst asserted mid-fill -> occupancy 0 immediately.
